// File: rtl/uart_pkg.sv
// Shared UART types: receiver FSM states and parity mode decoding.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  // Mode 3 is reserved and behaves as no parity.
  function automatic parity_t to_parity(input logic [1:0] m);
    case (m)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero while empty so stale storage never leaks out.
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime divisor/parity/stop config, per-frame error flags and an RX FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx,
  input  logic [DIV_W-1:0]                  div,
  input  logic [1:0]                        parity_mode,
  input  logic                              stop2,
  input  logic                              ien,
  input  logic                              ack,
  input  logic                              rd_en,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              rd_perr,
  output logic                              rd_ferr,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              overrun,
  input  logic                              clr_ovr,
  output logic                              busy,
  output logic                              irq
);
  localparam int BW = $clog2(DATA_W+1);

  uart_rx_state_t    state, state_nx;
  logic              rx_meta, rxs, rxs_prev;
  logic [DIV_W-1:0]  divl, cnt;
  logic [BW-1:0]     bitc;
  logic [DATA_W-1:0] shreg;
  parity_t           par_l;
  logic              stop2_l, stop_second, perr_r, ferr_r;
  logic              tick, push, push_ok, ovr_set;

  assign busy = (state != ST_IDLE);

  always_comb begin
    tick     = (state == ST_START) ? (cnt == {1'b0, divl[DIV_W-1:1]} - DIV_W'(1))
                                   : (cnt == divl - DIV_W'(1));
    state_nx = state;
    push     = 1'b0;
    case (state)
      ST_IDLE:   if (rxs_prev && !rxs) state_nx = ST_START;
      ST_START:  if (tick) state_nx = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && bitc == BW'(DATA_W-1))
                   state_nx = (par_l != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_nx = ST_STOP;
      ST_STOP:   if (tick && (!stop2_l || stop_second)) begin
                   state_nx = ST_IDLE;
                   push     = 1'b1;
                 end
      default:   state_nx = ST_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO only drops without rd_en.
  assign push_ok = push && (!full || rd_en);
  assign ovr_set = push && full && !rd_en;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      rxs_prev    <= 1'b1;
      cnt         <= '0;
      divl        <= '0;
      bitc        <= '0;
      shreg       <= '0;
      par_l       <= PAR_NONE;
      stop2_l     <= 1'b0;
      stop_second <= 1'b0;
      perr_r      <= 1'b0;
      ferr_r      <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
      if (state == ST_IDLE || tick || state_nx != state) cnt <= '0;
      else                                                cnt <= cnt + DIV_W'(1);
      case (state)
        ST_IDLE: if (rxs_prev && !rxs) begin
          divl        <= (div < DIV_W'(2)) ? DIV_W'(2) : div;
          bitc        <= '0;
          perr_r      <= 1'b0;
          ferr_r      <= 1'b0;
          stop_second <= 1'b0;
        end
        ST_START: if (tick && !rxs) begin
          par_l   <= to_parity(parity_mode);
          stop2_l <= stop2;
        end
        ST_DATA: if (tick) begin
          shreg <= {rxs, shreg[DATA_W-1:1]};
          bitc  <= bitc + BW'(1);
        end
        ST_PARITY: if (tick) perr_r <= ((^shreg) ^ rxs) != (par_l == PAR_ODD);
        ST_STOP: if (tick) begin
          ferr_r      <= ferr_r | ~rxs;
          stop_second <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)                            irq <= 1'b0;
    else if (ien && (push_ok || ovr_set)) irq <= 1'b1;
    else if (ack)                       irq <= 1'b0;
  end

  sync_fifo #(.WIDTH(DATA_W+2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata ({ferr_r | ~rxs, perr_r, shreg}),
    .pop   (rd_en),
    .rdata ({rd_ferr, rd_perr, rd_data}),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are bit-banged on rx, expected entries queued and drained.
module tb_uart_rx_fifo;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, rx, stop2, ien, ack, rd_en, clr_ovr;
  logic [DIV_W-1:0]  div;
  logic [1:0]        parity_mode;
  logic [DATA_W-1:0] rd_data;
  logic              rd_perr, rd_ferr, empty, full, overrun, busy, irq;
  logic [2:0]        count;

  int nvec = 0;
  int nerr = 0;
  int div_cyc = 8;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .div(div), .parity_mode(parity_mode), .stop2(stop2),
    .ien(ien), .ack(ack), .rd_en(rd_en), .rd_data(rd_data), .rd_perr(rd_perr),
    .rd_ferr(rd_ferr), .empty(empty), .full(full), .count(count), .overrun(overrun),
    .clr_ovr(clr_ovr), .busy(busy), .irq(irq)
  );

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (div_cyc - 1) @(negedge clk);
  endtask

  // pbit < 0 means no parity bit on the wire.
  task automatic send_frame(input logic [7:0] d, input int pbit, input logic s1,
                            input int nstop, input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pbit >= 0) send_bit(pbit[0]);
    send_bit(s1);
    if (nstop == 2) send_bit(s2);
  endtask

  task automatic drain(input string name);
    logic [9:0] e, got;
    int guard = 0;
    while (exp_q.size() > 0 && guard < 32) begin
      guard++;
      @(negedge clk);
      e   = exp_q.pop_front();
      got = {rd_ferr, rd_perr, rd_data};
      nvec++;
      if (empty || got !== e) begin
        nerr++;
        $display("FAIL %s entry: got %h (empty=%b) exp %h", name, got, empty, e);
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    @(negedge clk);
    nvec++;
    if (empty !== 1'b1) begin
      nerr++;
      $display("FAIL %s drained_empty: got %b exp 1", name, empty);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; div = 16'd8; parity_mode = 2'd0; stop2 = 1'b0;
    ien = 1'b0; ack = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({empty, full, count, busy, irq, overrun, rd_data, rd_perr, rd_ferr} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_state: got e%b f%b c%0d b%b i%b o%b d%h p%b r%b exp e1 f0 c0 b0 i0 o0 d00 p0 r0",
               empty, full, count, busy, irq, overrun, rd_data, rd_perr, rd_ferr);
    end
  endtask

  task automatic test_basic;
    ien = 1'b1;
    exp_q.push_back({2'b00, 8'h55});
    fork
      send_frame(8'h55, -1, 1'b1, 1, 1'b1);
      begin
        repeat (79) @(negedge clk);
        nvec++;
        if (irq !== 1'b0) begin nerr++; $display("FAIL irq_before_push: got %b exp 0", irq); end
        @(negedge clk);
        nvec++;
        if (irq !== 1'b1) begin nerr++; $display("FAIL irq_after_push: got %b exp 1", irq); end
      end
    join
    nvec++;
    if (count !== 3'd1) begin nerr++; $display("FAIL basic_count: got %0d exp 1", count); end
    drain("basic");
    @(negedge clk); ack = 1'b1; @(negedge clk); ack = 1'b0;
  endtask

  task automatic test_parity;
    parity_mode = 2'd1;
    exp_q.push_back({2'b01, 8'hA3});
    send_frame(8'hA3, 1, 1'b1, 1, 1'b1);
    parity_mode = 2'd2;
    exp_q.push_back({2'b00, 8'hA3});
    send_frame(8'hA3, 1, 1'b1, 1, 1'b1);
    parity_mode = 2'd0;
    nvec++;
    if (count !== 3'd2) begin nerr++; $display("FAIL parity_count: got %0d exp 2", count); end
    drain("parity");
  endtask

  task automatic test_ferr_glitch;
    stop2 = 1'b1;
    exp_q.push_back({2'b10, 8'h5A});
    send_frame(8'h5A, -1, 1'b1, 2, 1'b0);
    repeat (100) @(negedge clk);
    nvec++;
    if (count !== 3'd1 || busy !== 1'b0) begin
      nerr++; $display("FAIL break_no_rearm: got count %0d busy %b exp 1 0", count, busy);
    end
    rx = 1'b1;
    repeat (10) @(negedge clk);
    nvec++;
    if (count !== 3'd1) begin nerr++; $display("FAIL break_release: got %0d exp 1", count); end
    drain("ferr");
    stop2 = 1'b0;
    div = 16'd16; div_cyc = 16;
    @(negedge clk); rx = 1'b0;
    @(negedge clk);
    @(negedge clk); rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL glitch_start: got busy %b exp 1", busy); end
    repeat (20) @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || empty !== 1'b1) begin
      nerr++; $display("FAIL glitch_reject: got busy %b empty %b exp 0 1", busy, empty);
    end
    div = 16'd8; div_cyc = 8;
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    for (int k = 1; k <= 5; k++) begin
      d = 8'h20 + 8'(k);
      if (k <= 4) exp_q.push_back({2'b00, d});
      send_frame(d, -1, 1'b1, 1, 1'b1);
    end
    nvec++;
    if (count !== 3'd4 || full !== 1'b1 || overrun !== 1'b1) begin
      nerr++; $display("FAIL overrun_drop: got count %0d full %b ovr %b exp 4 1 1", count, full, overrun);
    end
    drain("overrun");
    @(negedge clk); clr_ovr = 1'b1; @(negedge clk); clr_ovr = 1'b0;
    nvec++;
    if (overrun !== 1'b0) begin nerr++; $display("FAIL clr_ovr: got %b exp 0", overrun); end
    for (int k = 1; k <= 4; k++) begin
      d = 8'h40 + 8'(k);
      exp_q.push_back({2'b00, d});
      send_frame(d, -1, 1'b1, 1, 1'b1);
    end
    exp_q.push_back({2'b00, 8'h45});
    fork
      send_frame(8'h45, -1, 1'b1, 1, 1'b1);
      begin
        logic [9:0] e;
        repeat (79) @(negedge clk);
        e = exp_q.pop_front();
        nvec++;
        if ({rd_ferr, rd_perr, rd_data} !== e) begin
          nerr++; $display("FAIL pop_on_full: got %h exp %h", {rd_ferr, rd_perr, rd_data}, e);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    nvec++;
    if (count !== 3'd4 || overrun !== 1'b0) begin
      nerr++; $display("FAIL full_with_pop: got count %0d ovr %b exp 4 0", count, overrun);
    end
    drain("full_pop");
  endtask

  task automatic test_irq_ack;
    ien = 1'b1;
    @(negedge clk); ack = 1'b1; @(negedge clk); ack = 1'b0;
    nvec++;
    if (irq !== 1'b0) begin nerr++; $display("FAIL irq_cleared: got %b exp 0", irq); end
    exp_q.push_back({2'b00, 8'hC7});
    fork
      send_frame(8'hC7, -1, 1'b1, 1, 1'b1);
      begin
        repeat (79) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        nvec++;
        if (irq !== 1'b1) begin nerr++; $display("FAIL set_beats_ack: got %b exp 1", irq); end
      end
    join
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    nvec++;
    if (irq !== 1'b0) begin nerr++; $display("FAIL ack_clears: got %b exp 0", irq); end
    drain("irq");
  endtask

  task automatic test_rst_mid;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL mid_frame_busy: got %b exp 1", busy); end
    @(negedge clk); rst = 1'b1; rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({busy, count, empty, overrun, irq} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL mid_reset: got b%b c%0d e%b o%b i%b exp b0 c0 e1 o0 i0",
                       busy, count, empty, overrun, irq);
    end
    exp_q.push_back({2'b00, 8'h3C});
    send_frame(8'h3C, -1, 1'b1, 1, 1'b1);
    nvec++;
    if (count !== 3'd1) begin nerr++; $display("FAIL post_reset_count: got %0d exp 1", count); end
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_ferr_glitch();
    test_overrun();
    test_irq_ack();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
